// File: rtl/dsp_bus_pkg.sv
// Shared types and DSP register-bus address constants for the bus initiator.
package dsp_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int MOD_SEL_MSB = 19;
  localparam int MOD_SEL_LSB = 16;

  localparam logic [15:0] REG_INPUT_SELECT  = 16'h0;
  localparam logic [15:0] REG_OUTPUT_SELECT = 16'h4;
  localparam logic [15:0] REG_SATURATION    = 16'h8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic [3:0] mod_sel(input logic [31:0] addr);
    return addr[MOD_SEL_MSB:MOD_SEL_LSB];
  endfunction

endpackage

// File: rtl/dsp_bus_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; storage is not reset, only the pointers.
module dsp_bus_cmd_fifo
  import dsp_bus_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dsp_bus_initiator.sv
// DSP register-bus master fed by a command FIFO; one strobe and one response per command.
// Define DSP_BUS_INITIATOR_TIMEOUT_EN to build the WAIT-state timeout counter.
module dsp_bus_initiator
  import dsp_bus_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  output logic [31:0] sys_addr_o,
  output logic [31:0] sys_wdata_o,
  output logic [3:0]  sys_sel_o,
  output logic        sys_wen_o,
  output logic        sys_ren_o,
  input  logic [31:0] sys_rdata_i,
  input  logic        sys_ack_i,
  input  logic        sys_err_i
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;
  cmd_t   push_cmd, head_cmd;
  logic   fifo_full, fifo_empty;
  logic   pop, bus_done, rsp_done, cmd_we;

  assign push_cmd    = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
  assign cmd_ready_o = !fifo_full;
  assign busy_o      = (state != ST_IDLE) || !fifo_empty;

  dsp_bus_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .push    (cmd_valid_i),
    .wr_data (push_cmd),
    .pop     (pop),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef DSP_BUS_INITIATOR_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        wait_expired;
  logic        tmo;
  logic        rsp_to_q;

  // Counts WAIT cycles; saturates instead of wrapping.
  assign wait_expired  = (wait_cnt >= TO_LAST);
  assign rsp_timeout_o = rsp_to_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && wait_cnt != 16'hFFFF) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TO_LAST;
  assign rsp_timeout_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    bus_done   = 1'b0;
    rsp_done   = 1'b0;
`ifdef DSP_BUS_INITIATOR_TIMEOUT_EN
    tmo        = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (sys_ack_i || sys_err_i) begin
          bus_done   = 1'b1;
          state_next = ST_RESP;
        end
`ifdef DSP_BUS_INITIATOR_TIMEOUT_EN
        else if (wait_expired) begin
          tmo        = 1'b1;
          state_next = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus strobes are registered off the pop so they land in the ISSUE cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_we      <= 1'b0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_sel_o   <= '0;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
`ifdef DSP_BUS_INITIATOR_TIMEOUT_EN
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      sys_wen_o <= 1'b0;
      sys_ren_o <= 1'b0;
      sys_sel_o <= '0;
      if (pop) begin
        cmd_we      <= head_cmd.we;
        sys_addr_o  <= head_cmd.addr;
        sys_wdata_o <= head_cmd.wdata;
        sys_wen_o   <= head_cmd.we;
        sys_ren_o   <= !head_cmd.we;
        sys_sel_o   <= 4'hF;
      end
      if (bus_done) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= sys_err_i;
        rsp_rdata_o <= (!cmd_we && !sys_err_i) ? sys_rdata_i : '0;
      end
`ifdef DSP_BUS_INITIATOR_TIMEOUT_EN
      if (tmo) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= 1'b0;
        rsp_rdata_o <= '0;
        rsp_to_q    <= 1'b1;
      end
      if (rsp_done) rsp_to_q <= 1'b0;
`endif
      if (rsp_done) begin
        rsp_valid_o <= 1'b0;
        rsp_err_o   <= 1'b0;
        rsp_rdata_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_bus_initiator.sv
// Directed bench for dsp_bus_initiator: cycle-exact strobes, responses, backpressure, timeout, reset.
module tb_dsp_bus_initiator;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic [31:0] sys_addr_o;
  logic [31:0] sys_wdata_o;
  logic [3:0]  sys_sel_o;
  logic        sys_wen_o;
  logic        sys_ren_o;
  logic [31:0] sys_rdata_i;
  logic        sys_ack_i;
  logic        sys_err_i;

  logic        man_ack = 1'b0, man_err = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_en = 1'b0, auto_ack = 1'b0, pend = 1'b0;
  logic [31:0] auto_rdata = '0, pend_data = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] t3_exp [5] = '{32'hBFCFFFFF, 32'hBFCFFFFB, 32'hBFCFFFF7, 32'hBFCFFFF3, 32'hBFCFFFEF};

  assign sys_ack_i   = man_ack | auto_ack;
  assign sys_err_i   = man_err;
  assign sys_rdata_i = man_rdata | auto_rdata;

  always #5 clk = ~clk;

  dsp_bus_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o),
    .sys_addr_o    (sys_addr_o),
    .sys_wdata_o   (sys_wdata_o),
    .sys_sel_o     (sys_sel_o),
    .sys_wen_o     (sys_wen_o),
    .sys_ren_o     (sys_ren_o),
    .sys_rdata_i   (sys_rdata_i),
    .sys_ack_i     (sys_ack_i),
    .sys_err_i     (sys_err_i)
  );

  // Responder that acks one cycle after each strobe and returns ~addr.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      auto_ack   = auto_en && pend;
      auto_rdata = (auto_en && pend) ? pend_data : '0;
      pend       = sys_wen_o || sys_ren_o;
      pend_data  = ~sys_addr_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    step();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    int  n;
    logic seen;

    // Reset state
    step();
    check("rst_wen", sys_wen_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    step();
    rstn_i = 1'b1;
    step();
    check("rst_ready", cmd_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_sel", sys_sel_o, 0);
    check("rst_addr", sys_addr_o, 0);

    // Test 1: write, ack in cycle 3
    push(1'b1, 32'h40350000, 32'h0000000A);
    check("t1_c1_wen", sys_wen_o, 0);
    step();
    check("t1_c2_wen", sys_wen_o, 1);
    check("t1_c2_ren", sys_ren_o, 0);
    check("t1_c2_sel", sys_sel_o, 4'hF);
    check("t1_c2_addr", sys_addr_o, 32'h40350000);
    check("t1_c2_wdata", sys_wdata_o, 32'h0000000A);
    step();
    check("t1_c3_wen", sys_wen_o, 0);
    check("t1_c3_valid", rsp_valid_o, 0);
    check("t1_c3_addr_hold", sys_addr_o, 32'h40350000);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("t1_c4_valid", rsp_valid_o, 1);
    check("t1_c4_err", rsp_err_o, 0);
    check("t1_c4_timeout", rsp_timeout_o, 0);
    check("t1_c4_rdata", rsp_rdata_o, 0);
    step();
    check("t1_c5_valid", rsp_valid_o, 0);
    check("t1_c5_busy", busy_o, 0);

    // Test 2: read returning 3
    push(1'b0, 32'h40300008, 32'h0);
    check("t2_c1_ren", sys_ren_o, 0);
    step();
    check("t2_c2_ren", sys_ren_o, 1);
    check("t2_c2_wen", sys_wen_o, 0);
    step();
    check("t2_c3_ren", sys_ren_o, 0);
    man_ack = 1'b1;
    man_rdata = 32'h00000003;
    step();
    man_ack = 1'b0;
    man_rdata = '0;
    check("t2_valid", rsp_valid_o, 1);
    check("t2_rdata", rsp_rdata_o, 32'h00000003);
    step();
    step();

    // Test 3: backpressure, 7 offered, 5 accepted, drained in order
    auto_en = 1'b1;
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_we_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cmd_addr_i = 32'h40300000 + 32'(i * 4);
      check($sformatf("t3_ready%0d", i), cmd_ready_o, 32'(i < 5));
      step();
    end
    cmd_valid_i = 1'b0;
    check("t3_busy", busy_o, 1);
    check("t3_hold_valid", rsp_valid_o, 1);
    check("t3_hold_rdata", rsp_rdata_o, 32'hBFCFFFFF);
    rsp_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      if (rsp_valid_o) begin
        check($sformatf("t3_rsp%0d", n), rsp_rdata_o, t3_exp[n]);
        n++;
      end
      step();
    end
    check("t3_count", n, 5);
    auto_en = 1'b0;
    step();
    step();
    check("t3_idle", busy_o, 0);

    // Test 4: silent responder
    push(1'b0, 32'h40300000, 32'h0);
    seen = 1'b0;
`ifdef DSP_BUS_INITIATOR_TIMEOUT_EN
    for (int c = 1; c < 18; c++) begin
      if (rsp_valid_o) seen = 1'b1;
      step();
    end
    check("t4_early", seen, 0);
    check("t4_c18_valid", rsp_valid_o, 0);
    step();
    check("t4_c19_valid", rsp_valid_o, 1);
    check("t4_timeout", rsp_timeout_o, 1);
    check("t4_rdata", rsp_rdata_o, 0);
    check("t4_err", rsp_err_o, 0);
`else
    for (int c = 1; c < 100; c++) begin
      if (rsp_valid_o) seen = 1'b1;
      step();
    end
    check("t4_no_rsp", seen, 0);
    check("t4_busy", busy_o, 1);
    man_ack = 1'b1;
    man_rdata = 32'h12345678;
    step();
    man_ack = 1'b0;
    man_rdata = '0;
    check("t4_valid", rsp_valid_o, 1);
    check("t4_rdata", rsp_rdata_o, 32'h12345678);
    check("t4_timeout", rsp_timeout_o, 0);
    check("t4_err", rsp_err_o, 0);
`endif
    step();
    step();

    // Test 5: ack and err together
    push(1'b0, 32'h40300004, 32'h0);
    step();
    step();
    man_ack = 1'b1;
    man_err = 1'b1;
    man_rdata = 32'hDEADBEEF;
    step();
    man_ack = 1'b0;
    man_err = 1'b0;
    man_rdata = '0;
    check("t5_valid", rsp_valid_o, 1);
    check("t5_err", rsp_err_o, 1);
    check("t5_rdata", rsp_rdata_o, 0);
    step();
    step();

    // Test 6: reset during WAIT with a second command queued
    push(1'b1, 32'h40350004, 32'h00000011);
    push(1'b1, 32'h40350008, 32'h00000022);
    step();
    rstn_i = 1'b0;
    #1;
    check("t6_wen", sys_wen_o, 0);
    check("t6_ren", sys_ren_o, 0);
    check("t6_valid", rsp_valid_o, 0);
    check("t6_addr", sys_addr_o, 0);
    check("t6_busy_in_rst", busy_o, 0);
    step();
    rstn_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid_o || sys_wen_o || sys_ren_o) seen = 1'b1;
      step();
    end
    check("t6_no_rsp", seen, 0);
    check("t6_ready", cmd_ready_o, 1);
    check("t6_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_bus_initiator.md
Name: dsp_bus_initiator

Overview:
- Bus master that drives the DSP register bus (sys_addr/sys_wdata/sys_sel/sys_wen/sys_ren in; sys_rdata/sys_ack/sys_err out) from an internal command stream.
- Used by on-chip sequencers (lock acquisition, sweep setup) to program routing and module registers without the PS.
- Buffers commands in a small FIFO, issues one single-cycle bus strobe per command, waits for ack/err and returns exactly one response per command.

Parameters:
- CMD_DEPTH, 4, command FIFO depth; power of two, minimum 2.
- TIMEOUT_CYCLES, 255, cycles to wait for ack/err before declaring a timeout; range 1..65535.

Ports:
- clk_i  in  1  processing clock
- rstn_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command FIFO not full
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  32  bus address
- cmd_wdata_i  in  32  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data; 0 for writes, errors and timeouts
- rsp_err_o  out  1  responder signalled sys_err
- rsp_timeout_o  out  1  no ack/err within TIMEOUT_CYCLES
- busy_o  out  1  FSM not IDLE or FIFO not empty
- sys_addr_o  out  32  bus address
- sys_wdata_o  out  32  bus write data
- sys_sel_o  out  4  byte select; always 4'hF during a strobe
- sys_wen_o  out  1  write strobe
- sys_ren_o  out  1  read strobe
- sys_rdata_i  in  32  read data from responder
- sys_ack_i  in  1  responder acknowledge
- sys_err_i  in  1  responder error

Behaviour:
- Reset (async, immediate):
  - All outputs are 0 except cmd_ready_o, which is 1 after reset is released.
  - FIFO is emptied and the FSM enters IDLE.
  - Reset during WAIT or RESP discards the in-flight command and produces no response.
- Command handshake:
  - A command is pushed when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !fifo_full.
  - Push while full is impossible because ready is low. Simultaneous push and pop while full is not accepted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is not empty, pop the head into the command register and go to ISSUE.
  - ISSUE: exactly one cycle.
    - Assert sys_wen_o (write) or sys_ren_o (read) with sys_addr_o/sys_wdata_o/sys_sel_o registered.
    - Clear the timeout counter; go to WAIT.
  - WAIT: strobes low; addr/wdata held stable.
    - On sys_ack_i or sys_err_i: capture sys_rdata_i (reads only), set err = sys_err_i, go to RESP.
    - Ack and err together count as err = 1.
    - Otherwise increment the counter. At TIMEOUT_CYCLES: set timeout = 1, rdata = 0, go to RESP.
  - RESP: rsp_valid_o = 1, data stable until rsp_ready_i; then go to IDLE.
- Ack/err seen in IDLE, ISSUE or RESP is ignored.
- A late ack after a timeout that arrives during a later WAIT is accepted as that command's ack. Firmware must size TIMEOUT_CYCLES so this cannot happen.
- Latency:
  - Command pushed in cycle N reaches the strobe at N+2 (IDLE pop N+1, ISSUE N+2).
  - With the responder's registered ack at N+3, rsp_valid_o rises at N+4.
  - Throughput is one command per 4 cycles when rsp_ready_i = 1.
- Capacity: CMD_DEPTH commands in the FIFO plus one in the FSM.
- Counter width is 16 bits and saturates. No wrap-around.

Optional Feature:
- Macro DSP_BUS_INITIATOR_TIMEOUT_EN.
- Defined: timeout logic as described above; rsp_timeout_o is functional.
- Undefined: the counter is not built, WAIT exits only on ack/err, and rsp_timeout_o is tied to 0. TIMEOUT_CYCLES is ignored.

Decomposition:
- Package dsp_bus_pkg holds:
  - FSM state enum
  - bus address field constants: module select bits [19:16], REG_INPUT_SELECT = 16'h0, REG_OUTPUT_SELECT = 16'h4, REG_SATURATION = 16'h8
  - command struct {we, addr, wdata}
- Sub-module dsp_bus_cmd_fifo: synchronous FIFO, width 65, depth CMD_DEPTH, with full/empty flags.

Test Plan:
1. Write to addr 0x40350000, wdata 0x0000000A, pushed at cycle 0 → sys_wen_o high only in cycle 2 with sel 4'hF. Ack in cycle 3 → rsp_valid_o in cycle 4, err = 0, timeout = 0, rdata = 0.
2. Read from 0x40300008, responder returns 0x00000003 with ack → rsp_rdata_o = 0x00000003, sys_ren_o pulses exactly one cycle.
3. CMD_DEPTH = 4, rsp_ready_i = 0, 7 back-to-back commands → 5 accepted, cmd_ready_o low from the 6th. Releasing rsp_ready_i drains 5 responses in order.
4. Macro defined, TIMEOUT_CYCLES = 16, responder silent → rsp_timeout_o = 1 after 16 WAIT cycles. With macro undefined, no response until ack is injected at cycle 100, then a normal response.
5. Responder asserts sys_ack_i and sys_err_i together → rsp_err_o = 1, rsp_rdata_o = 0.
6. rstn_i asserted during WAIT → sys_wen_o/sys_ren_o/rsp_valid_o drop immediately, no response after release, cmd_ready_o = 1, busy_o = 0.
